// File: rtl/ann_sequencer_if.sv
// ANN sequencer bundle: start/status, parameter-memory read port
// and the single-MAC datapath strobes.
interface ann_sequencer_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              ld_in;
   logic              rst_sum;
   logic              ld_bias_LSB;
   logic              ld_bias_MSB;
   logic              ld_weight;
   logic              shift_in;
   logic              change;
   logic              ld_multiplication;
   logic              bias_addition;
   logic              ReLU_computation;
   logic              ld_max_func;
   logic [3:0]        ld_neuron;

   modport master (
      input  start,
      output busy, done, mem_addr, mem_rd,
      output ld_in, rst_sum, ld_bias_LSB, ld_bias_MSB,
      output ld_weight, shift_in, change, ld_multiplication,
      output bias_addition, ReLU_computation, ld_max_func,
      output ld_neuron
   );

   modport slave (
      output start,
      input  busy, done, mem_addr, mem_rd,
      input  ld_in, rst_sum, ld_bias_LSB, ld_bias_MSB,
      input  ld_weight, shift_in, change, ld_multiplication,
      input  bias_addition, ReLU_computation, ld_max_func,
      input  ld_neuron
   );
endinterface

// File: rtl/ann_sequencer.sv
// Control sequencer for the ANN single-MAC datapath: fetches inputs,
// then bias and weights per neuron, and strobes the datapath.
module ann_sequencer #(
   parameter int N_IN     = 32,
   parameter int N_NEURON = 10,
   parameter int ADDR_W   = 10,
   parameter int IN_BASE  = 0,
   parameter int W_BASE   = 32,
   parameter int B_BASE   = 352
) (
   input  logic            clk,
   input  logic            rst,
   ann_sequencer_if.master bus
);
   localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);
   localparam logic [KW-1:0] K_PEN  = KW'(N_IN - 2);
   localparam logic [3:0]    N_LAST = 4'(N_NEURON - 1);

   typedef enum logic [3:0] {
      IDLE, PRE, LOAD_IN, CLR, BIAS_L, BIAS_H,
      MAC, BIAS_ADD, RELU, MAX, DONE
   } state_t;

   state_t        state;
   logic [KW-1:0] k;
   logic [3:0]    n;

   // Outputs are set on the edge entering the state they belong to,
   // so each address goes out one cycle before its word is consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= IDLE;
         k                     <= '0;
         n                     <= '0;
         bus.busy              <= 1'b0;
         bus.done              <= 1'b0;
         bus.mem_addr          <= '0;
         bus.mem_rd            <= 1'b0;
         bus.ld_in             <= 1'b0;
         bus.rst_sum           <= 1'b0;
         bus.ld_bias_LSB       <= 1'b0;
         bus.ld_bias_MSB       <= 1'b0;
         bus.ld_weight         <= 1'b0;
         bus.shift_in          <= 1'b0;
         bus.change            <= 1'b0;
         bus.ld_multiplication <= 1'b0;
         bus.bias_addition     <= 1'b0;
         bus.ReLU_computation  <= 1'b0;
         bus.ld_max_func       <= 1'b0;
         bus.ld_neuron         <= '0;
      end else begin
         bus.done              <= 1'b0;
         bus.mem_addr          <= '0;
         bus.mem_rd            <= 1'b0;
         bus.ld_in             <= 1'b0;
         bus.rst_sum           <= 1'b0;
         bus.ld_bias_LSB       <= 1'b0;
         bus.ld_bias_MSB       <= 1'b0;
         bus.ld_weight         <= 1'b0;
         bus.shift_in          <= 1'b0;
         bus.ld_multiplication <= 1'b0;
         bus.bias_addition     <= 1'b0;
         bus.ReLU_computation  <= 1'b0;
         bus.ld_max_func       <= 1'b0;
         unique case (state)
            IDLE: if (bus.start) begin
               state        <= PRE;
               bus.busy     <= 1'b1;
               bus.mem_rd   <= 1'b1;
               bus.mem_addr <= ADDR_W'(IN_BASE);
            end
            PRE: begin
               state     <= LOAD_IN;
               k         <= '0;
               bus.ld_in <= 1'b1;
               if (N_IN > 1) begin
                  bus.mem_rd   <= 1'b1;
                  bus.mem_addr <= ADDR_W'(IN_BASE + 1);
               end
            end
            LOAD_IN: if (k == K_LAST) begin
               state         <= CLR;
               k             <= '0;
               n             <= '0;
               bus.rst_sum   <= 1'b1;
               bus.ld_neuron <= '0;
               bus.mem_rd    <= 1'b1;
               bus.mem_addr  <= ADDR_W'(B_BASE);
            end else begin
               k         <= k + KW'(1);
               bus.ld_in <= 1'b1;
               if (k != K_PEN) begin
                  bus.mem_rd   <= 1'b1;
                  bus.mem_addr <= ADDR_W'(IN_BASE + int'(k) + 2);
               end
            end
            CLR: begin
               state           <= BIAS_L;
               bus.ld_bias_LSB <= 1'b1;
               bus.mem_rd      <= 1'b1;
               bus.mem_addr    <= ADDR_W'(B_BASE + 2 * int'(n) + 1);
            end
            BIAS_L: begin
               state           <= BIAS_H;
               bus.ld_bias_MSB <= 1'b1;
               bus.mem_rd      <= 1'b1;
               bus.mem_addr    <= ADDR_W'(W_BASE + int'(n) * N_IN);
            end
            BIAS_H: begin
               state                 <= MAC;
               k                     <= '0;
               bus.ld_weight         <= 1'b1;
               bus.shift_in          <= 1'b1;
               bus.change            <= ~bus.change;
               bus.ld_multiplication <= 1'b1;
               if (N_IN > 1) begin
                  bus.mem_rd   <= 1'b1;
                  bus.mem_addr <= ADDR_W'(W_BASE + int'(n) * N_IN + 1);
               end
            end
            MAC: if (k == K_LAST) begin
               state             <= BIAS_ADD;
               k                 <= '0;
               bus.bias_addition <= 1'b1;
            end else begin
               k             <= k + KW'(1);
               bus.ld_weight <= 1'b1;
               bus.shift_in  <= 1'b1;
               bus.change    <= ~bus.change;
               if (k != K_PEN) begin
                  bus.mem_rd   <= 1'b1;
                  bus.mem_addr <=
                     ADDR_W'(W_BASE + int'(n) * N_IN + int'(k) + 2);
               end
            end
            BIAS_ADD: begin
               state                <= RELU;
               bus.ReLU_computation <= 1'b1;
            end
            RELU: if (n == N_LAST) begin
               state           <= MAX;
               bus.ld_max_func <= 1'b1;
               bus.ld_neuron   <= '0;
            end else begin
               state         <= CLR;
               n             <= n + 4'd1;
               bus.rst_sum   <= 1'b1;
               bus.ld_neuron <= n + 4'd1;
               bus.mem_rd    <= 1'b1;
               bus.mem_addr  <= ADDR_W'(B_BASE + 2 * (int'(n) + 1));
            end
            MAX: begin
               state    <= DONE;
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
            end
            DONE: begin
               state <= IDLE;
               n     <= '0;
               k     <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ann_sequencer.sv
// Self-checking bench for ann_sequencer: default and small configs
// against a cycle-offset reference model.
module tb_ann_sequencer;
   localparam int NI1  = 32;
   localparam int NN1  = 10;
   localparam int NI2  = 4;
   localparam int NN2  = 2;
   localparam int TOT1 = 3 + NI1 + NN1 * (NI1 + 5);
   localparam int TOT2 = 3 + NI2 + NN2 * (NI2 + 5);

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       mem_rd;
      logic [9:0] mem_addr;
      logic       ld_in;
      logic       rst_sum;
      logic       bl;
      logic       bh;
      logic       lw;
      logic       si;
      logic       lm;
      logic       ba;
      logic       relu;
      logic       lmax;
      logic [3:0] nrn;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ann_sequencer_if #(.ADDR_W(10)) b1 ();
   ann_sequencer_if #(.ADDR_W(10)) b2 ();

   ann_sequencer dut1 (.clk(clk), .rst(rst), .bus(b1));
   ann_sequencer #(.N_IN(NI2), .N_NEURON(NN2)) dut2 (
      .clk(clk), .rst(rst), .bus(b2)
   );

   int   errs = 0;
   int   checks = 0;
   int   t = 0;
   int   mc1 = 0;
   int   mc2 = 0;
   logic ec1 = 1'b0;
   logic ec2 = 1'b0;
   int   cnt [10];
   int   cnt_until = -1;
   int   t0;
   int   dq1 [$];
   int   dq2 [$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
      end
   endtask

   // Word consumed by the datapath in cycle c after the accept cycle.
   function automatic void word_at(input int c, input int ni, input int nn,
                                   output logic v, output logic [9:0] a);
      int j, n, p;
      v = 1'b0;
      a = '0;
      if (c >= 2 && c < 2 + ni) begin
         v = 1'b1;
         a = 10'(c - 2);
      end
      j = c - 2 - ni;
      if (j >= 0 && j < nn * (ni + 5)) begin
         n = j / (ni + 5);
         p = j % (ni + 5);
         if (p == 1) begin
            v = 1'b1;
            a = 10'(352 + 2 * n);
         end else if (p == 2) begin
            v = 1'b1;
            a = 10'(353 + 2 * n);
         end else if (p >= 3 && p < ni + 3) begin
            v = 1'b1;
            a = 10'(32 + n * ni + p - 3);
         end
      end
   endfunction

   function automatic out_t model_out(input int mc, input int ni, input int nn);
      out_t o;
      int tot, j, n, p;
      logic v;
      logic [9:0] a;
      o = '0;
      tot = 3 + ni + nn * (ni + 5);
      if (mc == 0) return o;
      o.busy = (mc < tot);
      o.done = (mc == tot);
      word_at(mc + 1, ni, nn, v, a);
      o.mem_rd = v;
      o.mem_addr = v ? a : 10'd0;
      o.ld_in = (mc >= 2 && mc < 2 + ni);
      j = mc - 2 - ni;
      if (j >= 0 && j < nn * (ni + 5)) begin
         n = j / (ni + 5);
         p = j % (ni + 5);
         o.nrn = 4'(n);
         o.rst_sum = (p == 0);
         o.bl = (p == 1);
         o.bh = (p == 2);
         o.lw = (p >= 3 && p < ni + 3);
         o.si = o.lw;
         o.lm = (p == 3);
         o.ba = (p == ni + 3);
         o.relu = (p == ni + 4);
      end
      o.lmax = (mc == tot - 1);
      return o;
   endfunction

   function automatic int model_next(input int mc, input logic s, input int tot);
      if (mc == 0) return s ? 1 : 0;
      if (mc == tot) return 0;
      return mc + 1;
   endfunction

`define OBS(o, b) \
   o.busy = b.busy; o.done = b.done; o.mem_rd = b.mem_rd; \
   o.mem_addr = b.mem_rd ? b.mem_addr : 10'd0; o.ld_in = b.ld_in; \
   o.rst_sum = b.rst_sum; o.bl = b.ld_bias_LSB; o.bh = b.ld_bias_MSB; \
   o.lw = b.ld_weight; o.si = b.shift_in; o.lm = b.ld_multiplication; \
   o.ba = b.bias_addition; o.relu = b.ReLU_computation; \
   o.lmax = b.ld_max_func; o.nrn = b.ld_neuron;

   task automatic tick(input logic s1, input logic s2, input logic r);
      out_t o1, o2, e1, e2;
      b1.start = s1;
      b2.start = s2;
      rst = r;
      @(posedge clk);
      t++;
      if (r) begin
         mc1 = 0; mc2 = 0; ec1 = 1'b0; ec2 = 1'b0;
      end else begin
         mc1 = model_next(mc1, s1, TOT1);
         mc2 = model_next(mc2, s2, TOT2);
      end
      #1;
      e1 = model_out(mc1, NI1, NN1);
      e2 = model_out(mc2, NI2, NN2);
      if (e1.lw) ec1 = ~ec1;
      if (e2.lw) ec2 = ~ec2;
      `OBS(o1, b1)
      `OBS(o2, b2)
      chk("dut1_out", 64'(o1), 64'(e1));
      chk("dut2_out", 64'(o2), 64'(e2));
      chk("dut1_change", 64'(b1.change), 64'(ec1));
      chk("dut2_change", 64'(b2.change), 64'(ec2));
      if (b1.done) dq1.push_back(t);
      if (b2.done) dq2.push_back(t);
      if (t <= cnt_until) begin
         cnt[0] += int'(b1.ld_in);
         cnt[1] += int'(b1.rst_sum);
         cnt[2] += int'(b1.ld_weight);
         cnt[3] += int'(b1.ld_bias_LSB);
         cnt[4] += int'(b1.ld_bias_MSB);
         cnt[5] += int'(b1.bias_addition);
         cnt[6] += int'(b1.ReLU_computation);
         cnt[7] += int'(b1.ld_max_func);
         cnt[8] += int'(b1.ld_multiplication);
         cnt[9] += int'(b1.done);
      end
   endtask

   initial begin
      int exp_cnt [10];
      exp_cnt = '{32, 10, 320, 10, 10, 10, 10, 1, 10, 1};
      b1.start = 1'b0;
      b2.start = 1'b0;
      foreach (cnt[i]) cnt[i] = 0;

      // Reset held 3 cycles, then idle
      repeat (3) tick(0, 0, 1);
      chk("rst_addr", 64'(b1.mem_addr), 64'd0);
      chk("rst_nrn", 64'(b1.ld_neuron), 64'd0);
      repeat (10) tick(0, 0, 0);

      // Full default run with ignored restarts, then back-to-back run
      dq1.delete();
      dq2.delete();
      t = 0;
      cnt_until = TOT1;
      tick(1, 1, 0);
      while (t < 2 * TOT1 + 5) tick(t == 50 || t == 405 || t == 406, 0, 0);
      cnt_until = -1;
      foreach (cnt[i]) chk("strobe_count", 64'(cnt[i]), 64'(exp_cnt[i]));
      chk("done_count", 64'(dq1.size()), 64'd2);
      chk("done_1st", 64'(dq1.size() > 0 ? dq1[0] : -1), 64'd405);
      chk("done_2nd", 64'(dq1.size() > 1 ? dq1[1] : -1), 64'd811);
      chk("small_done", 64'(dq2.size() > 0 ? dq2[0] : -1), 64'd25);
      chk("small_done_count", 64'(dq2.size()), 64'd1);

      // Random start/reset traffic on both configurations
      for (int i = 0; i < 3000; i++)
         tick($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 799) == 0);

      // Reset mid-MAC of neuron 4, then a fresh run
      for (int i = 0; i < 1000 && (mc1 != 0 || mc2 != 0); i++) tick(0, 0, 0);
      chk("drained", 64'(b1.busy | b2.busy), 64'd0);
      tick(1, 0, 0);
      for (int i = 0; i < 400 && mc1 != 2 + NI1 + 4 * (NI1 + 5) + 5; i++)
         tick(0, 0, 0);
      chk("mid_mac_lw", 64'(b1.ld_weight), 64'd1);
      chk("mid_mac_nrn", 64'(b1.ld_neuron), 64'd4);
      tick(0, 0, 1);
      chk("abort_busy", 64'(b1.busy), 64'd0);
      chk("abort_lw", 64'(b1.ld_weight), 64'd0);
      chk("abort_change", 64'(b1.change), 64'd0);
      dq1.delete();
      t0 = t;
      tick(1, 0, 0);
      chk("restart_rd", 64'(b1.mem_rd), 64'd1);
      chk("restart_addr", 64'(b1.mem_addr), 64'd0);
      repeat (TOT1 + 2) tick(0, 0, 0);
      chk("restart_done", 64'(dq1.size() > 0 ? dq1[0] - t0 : -1), 64'd405);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
`undef OBS
endmodule
